// File: rtl/set_assoc_cache_ctrl.sv
// set_assoc_cache_ctrl: N-way set-associative cache controller with per-set
// age-based LRU replacement, write-back of dirty victims, write-allocate
// without fill on clean write misses, and a valid/ready miss port to memory.
// Optional build macro: CACHE_STATS_EN adds saturating hit_count/miss_count
// outputs updated in LOOKUP and cleared by rst.
module set_assoc_cache_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int SETS   = 8,
    parameter int WAYS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
`ifdef CACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_FILL,
        ST_FILL_WAIT,
        ST_RESPOND
    } state_t;

    // One age per way; 0 = most recently used, WAYS-1 = replacement candidate.
    typedef logic [WAYS-1:0][WAY_W-1:0] age_vec_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [WAY_W-1:0]    victim_q;

    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     dirty_q [SETS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [DATA_W-1:0]   data_q  [SETS][WAYS];
    age_vec_t            age_q   [SETS];

    logic                req_ready_q;
    logic                resp_valid_q;
    logic                resp_hit_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic                mem_req_valid_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic [IDX_W-1:0]    idx_s;
    logic [TAG_W-1:0]    tag_s;
    logic                hit_s;
    logic [WAY_W-1:0]    hit_way_s;
    logic                inv_found_s;
    logic [WAY_W-1:0]    inv_way_s;
    logic [WAY_W-1:0]    lru_way_s;
    logic [WAY_W-1:0]    victim_s;

    assign idx_s = addr_q[IDX_W-1:0];
    assign tag_s = addr_q[ADDR_W-1:IDX_W];

    // Move the touched way to age 0 and age every way that was younger than it.
    function automatic age_vec_t lru_touch(input age_vec_t ages, input logic [WAY_W-1:0] way);
        age_vec_t         r;
        logic [WAY_W-1:0] old_age;
        old_age = ages[way];
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == way) begin
                r[w] = {WAY_W{1'b0}};
            end else if (ages[w] < old_age) begin
                r[w] = ages[w] + WAY_W'(1'b1);
            end else begin
                r[w] = ages[w];
            end
        end
        return r;
    endfunction

    // Tag compare across the set and victim choice (lowest invalid way, else oldest).
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = {WAY_W{1'b0}};
        inv_found_s = 1'b0;
        inv_way_s   = {WAY_W{1'b0}};
        lru_way_s   = {WAY_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_s && valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_W'(w);
            end else begin
                hit_s     = hit_s;
            end
            if (!inv_found_s && !valid_q[idx_s][w]) begin
                inv_found_s = 1'b1;
                inv_way_s   = WAY_W'(w);
            end else begin
                inv_found_s = inv_found_s;
            end
            if (age_q[idx_s][w] == WAY_W'(WAYS - 1)) begin
                lru_way_s = WAY_W'(w);
            end else begin
                lru_way_s = lru_way_s;
            end
        end
        victim_s = inv_found_s ? inv_way_s : lru_way_s;
    end

    // Controller FSM, tag/data/state arrays and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= {ADDR_W{1'b0}};
            we_q            <= 1'b0;
            wdata_q         <= {DATA_W{1'b0}};
            victim_q        <= {WAY_W{1'b0}};
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_hit_q      <= 1'b0;
            resp_rdata_q    <= {DATA_W{1'b0}};
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= {ADDR_W{1'b0}};
            mem_wdata_q     <= {DATA_W{1'b0}};
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= {WAYS{1'b0}};
                dirty_q[s] <= {WAYS{1'b0}};
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        addr_q      <= req_addr;
                        we_q        <= req_we;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_LOOKUP;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                ST_LOOKUP: begin
                    victim_q <= victim_s;
                    if (hit_s) begin
                        if (we_q) begin
                            data_q[idx_s][hit_way_s]  <= wdata_q;
                            dirty_q[idx_s][hit_way_s] <= 1'b1;
                            resp_rdata_q              <= wdata_q;
                        end else begin
                            resp_rdata_q              <= data_q[idx_s][hit_way_s];
                        end
                        age_q[idx_s] <= lru_touch(age_q[idx_s], hit_way_s);
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                        state_q      <= ST_RESPOND;
                    end else if (valid_q[idx_s][victim_s] && dirty_q[idx_s][victim_s]) begin
                        mem_req_valid_q <= 1'b1;
                        mem_we_q        <= 1'b1;
                        mem_addr_q      <= {tag_q[idx_s][victim_s], idx_s};
                        mem_wdata_q     <= data_q[idx_s][victim_s];
                        state_q         <= ST_WRITEBACK;
                    end else if (we_q) begin
                        // Clean write miss: the whole line is written, so no fill.
                        valid_q[idx_s][victim_s] <= 1'b1;
                        dirty_q[idx_s][victim_s] <= 1'b1;
                        tag_q[idx_s][victim_s]   <= tag_s;
                        data_q[idx_s][victim_s]  <= wdata_q;
                        age_q[idx_s]             <= lru_touch(age_q[idx_s], victim_s);
                        resp_valid_q             <= 1'b1;
                        resp_hit_q               <= 1'b0;
                        resp_rdata_q             <= wdata_q;
                        state_q                  <= ST_RESPOND;
                    end else begin
                        mem_req_valid_q <= 1'b1;
                        mem_we_q        <= 1'b0;
                        mem_addr_q      <= addr_q;
                        state_q         <= ST_FILL;
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_req_ready) begin
                        mem_we_q <= 1'b0;
                        if (we_q) begin
                            mem_req_valid_q          <= 1'b0;
                            valid_q[idx_s][victim_q] <= 1'b1;
                            dirty_q[idx_s][victim_q] <= 1'b1;
                            tag_q[idx_s][victim_q]   <= tag_s;
                            data_q[idx_s][victim_q]  <= wdata_q;
                            age_q[idx_s]             <= lru_touch(age_q[idx_s], victim_q);
                            resp_valid_q             <= 1'b1;
                            resp_hit_q               <= 1'b0;
                            resp_rdata_q             <= wdata_q;
                            state_q                  <= ST_RESPOND;
                        end else begin
                            mem_addr_q <= addr_q;
                            state_q    <= ST_FILL;
                        end
                    end else begin
                        state_q <= ST_WRITEBACK;
                    end
                end
                ST_FILL: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= ST_FILL_WAIT;
                    end else begin
                        state_q         <= ST_FILL;
                    end
                end
                ST_FILL_WAIT: begin
                    if (mem_resp_valid) begin
                        valid_q[idx_s][victim_q] <= 1'b1;
                        dirty_q[idx_s][victim_q] <= 1'b0;
                        tag_q[idx_s][victim_q]   <= tag_s;
                        data_q[idx_s][victim_q]  <= mem_rdata;
                        age_q[idx_s]             <= lru_touch(age_q[idx_s], victim_q);
                        resp_valid_q             <= 1'b1;
                        resp_hit_q               <= 1'b0;
                        resp_rdata_q             <= mem_rdata;
                        state_q                  <= ST_RESPOND;
                    end else begin
                        state_q <= ST_FILL_WAIT;
                    end
                end
                ST_RESPOND: begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    resp_valid_q    <= 1'b0;
                    mem_req_valid_q <= 1'b0;
                    req_ready_q     <= 1'b1;
                    state_q         <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_hit      = resp_hit_q;
    assign resp_rdata    = resp_rdata_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    // Saturating lookup statistics, one increment per LOOKUP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else if (state_q == ST_LOOKUP) begin
            if (hit_s && (hit_count_q != {32{1'b1}})) begin
                hit_count_q <= hit_count_q + 32'd1;
            end else if (!hit_s && (miss_count_q != {32{1'b1}})) begin
                miss_count_q <= miss_count_q + 32'd1;
            end else begin
                hit_count_q  <= hit_count_q;
            end
        end else begin
            hit_count_q <= hit_count_q;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Self-checking bench for set_assoc_cache_ctrl: directed steps followed by a
// randomized access stream, checked against a behavioural cache model that
// keeps each set as a recency-ordered list of ways plus a flat memory array.
module tb_set_assoc_cache_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NS = 8;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_hit;
    logic [DW-1:0] resp_rdata;
    logic          mem_req_valid, mem_req_ready, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0]   hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    set_assoc_cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SETS(NS), .WAYS(NW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
`ifdef CACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] memarr [256];
    bit            m_valid [NS][NW];
    bit            m_dirty [NS][NW];
    int            m_tag   [NS][NW];
    logic [DW-1:0] m_data  [NS][NW];
    int            order   [NS][NW];   // order[s][0] = most recent way
    int            m_hits, m_misses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                order[s][w]   = w;
            end
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic touch(input int s, input int w);
        int p = 0;
        for (int i = 0; i < NW; i++) if (order[s][i] == w) p = i;
        for (int i = p; i > 0; i--) order[s][i] = order[s][i-1];
        order[s][0] = w;
    endtask

    // One processor access with a reactive memory; optionally stalls
    // mem_req_ready, or applies rst while the fill response is outstanding.
    task automatic access(input bit we, input int addr, input logic [DW-1:0] wd,
                          input int stall, input bit abort);
        int s, t, hw, v, n_wb, n_fill, cnt, stall_left, wb_addr, fill_addr;
        bit hit, found, exp_wb, exp_fill, done, pending, prev_mv, prev_hs, abort_now, hs, mv_seen;
        logic [DW-1:0] wb_data, exp_rdata, prev_wdata;
        logic [AW-1:0] prev_addr;
        logic          prev_we;
        s = addr % NS;
        t = addr / NS;
        hit = 1'b0; hw = 0; found = 1'b0; v = 0;
        for (int w = 0; w < NW; w++)
            if (!hit && m_valid[s][w] && m_tag[s][w] == t) begin hit = 1'b1; hw = w; end
        for (int w = 0; w < NW; w++)
            if (!found && !m_valid[s][w]) begin found = 1'b1; v = w; end
        if (!found) v = order[s][NW-1];
        exp_wb   = !hit && m_valid[s][v] && m_dirty[s][v];
        wb_addr  = m_tag[s][v] * NS + s;
        wb_data  = m_data[s][v];
        exp_fill = !hit && !we;
        if (we) exp_rdata = wd;
        else if (hit) exp_rdata = m_data[s][hw];
        else exp_rdata = memarr[addr];
        if (hit) m_hits++; else m_misses++;

        n_wb = 0; n_fill = 0; cnt = 0; stall_left = stall; fill_addr = 0;
        done = 1'b0; pending = 1'b0; prev_mv = 1'b0; prev_hs = 1'b0; abort_now = 1'b0; mv_seen = 1'b0;
        prev_addr = '0; prev_wdata = '0; prev_we = 1'b0;

        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        chk("resp_single_cycle", 32'(resp_valid), 32'd0);
        req_valid = 1'b1; req_we = we; req_addr = AW'(addr); req_wdata = wd;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) req_valid = 1'b0;
            if (abort_now) begin
                rst = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                chk("abort_req_ready", 32'(req_ready), 32'd1);
                chk("abort_mem_req_valid", 32'(mem_req_valid), 32'd0);
                chk("abort_mem_addr", 32'(mem_addr), 32'd0);
                chk("abort_resp_valid", 32'(resp_valid), 32'd0);
                mem_resp_valid = 1'b1; mem_rdata = 8'hEE;   // late response, must be ignored
                @(negedge clk);
                mem_resp_valid = 1'b0;
                chk("late_resp_ignored", 32'(resp_valid), 32'd0);
                chk("late_resp_ready", 32'(req_ready), 32'd1);
                model_reset();
`ifdef CACHE_STATS_EN
                chk("stats_hit_reset", hit_count, 32'd0);
                chk("stats_miss_reset", miss_count, 32'd0);
`endif
                done = 1'b1;
            end else begin
                mem_resp_valid = 1'b0;
                if (resp_valid) begin
                    chk("resp_hit", 32'(resp_hit), 32'(hit));
                    chk("resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
                    if (hit) chk("hit_latency", 32'(cyc), 32'd2);
                    done = 1'b1;
                end
                if (mem_req_valid) mv_seen = 1'b1;
                if (mem_req_valid && prev_mv && !prev_hs) begin
                    chk("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
                    chk("mem_we_stable", 32'(mem_we), 32'(prev_we));
                    if (mem_we) chk("mem_wdata_stable", 32'(mem_wdata), 32'(prev_wdata));
                end
                if (pending) begin
                    cnt--;
                    if (cnt == 0) begin
                        mem_resp_valid = 1'b1; mem_rdata = memarr[fill_addr]; pending = 1'b0;
                    end
                end else begin
                    mem_resp_valid = ($urandom_range(0, 7) == 0);
                    mem_rdata = DW'($urandom);
                end
                if (mem_req_valid && stall_left > 0) begin
                    mem_req_ready = 1'b0; stall_left--;
                end else begin
                    mem_req_ready = 1'($urandom_range(0, 1));
                end
                hs = mem_req_valid && mem_req_ready;
                if (hs) begin
                    if (mem_we) begin
                        n_wb++;
                        chk("wb_addr", 32'(mem_addr), 32'(wb_addr));
                        chk("wb_data", 32'(mem_wdata), 32'(wb_data));
                        memarr[mem_addr] = mem_wdata;
                    end else begin
                        n_fill++;
                        chk("fill_addr", 32'(mem_addr), 32'(addr));
                        fill_addr = mem_addr;
                        if (abort) abort_now = 1'b1;
                        else begin pending = 1'b1; cnt = $urandom_range(1, 3); end
                    end
                end
                prev_mv = mem_req_valid; prev_hs = hs;
                prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
            end
        end
        mem_resp_valid = 1'b0;
        chk("resp_timeout", 32'(done), 32'd1);
        if (!abort) begin
            chk("wb_count", 32'(n_wb), 32'(exp_wb));
            chk("fill_count", 32'(n_fill), 32'(exp_fill));
            if (!exp_wb && !exp_fill) chk("no_mem_traffic", 32'(mv_seen), 32'd0);
            if (hit) begin
                if (we) begin m_data[s][hw] = wd; m_dirty[s][hw] = 1'b1; end
                touch(s, hw);
            end else begin
                m_valid[s][v] = 1'b1; m_tag[s][v] = t;
                m_data[s][v] = exp_rdata; m_dirty[s][v] = we;
                touch(s, v);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        for (int a = 0; a < 256; a++) memarr[a] = DW'($urandom);
        memarr[8'h12] = 8'hA5;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_hit", 32'(resp_hit), 32'd0);
        chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        rst = 1'b0;

        // Miss then hit on 0x12 (fill returns 0xA5)
        access(1'b0, 'h12, 8'h00, 0, 1'b0);
        access(1'b0, 'h12, 8'h00, 0, 1'b0);
        // Fill set 2, evict the LRU clean line
        access(1'b0, 'h02, 8'h00, 0, 1'b0);
        access(1'b0, 'h0A, 8'h00, 0, 1'b0);
        access(1'b0, 'h12, 8'h00, 0, 1'b0);
        access(1'b0, 'h1A, 8'h00, 0, 1'b0);
        access(1'b0, 'h22, 8'h00, 0, 1'b0);
        access(1'b0, 'h02, 8'h00, 0, 1'b0);
        // Dirty line then forced writeback
        access(1'b1, 'h0A, 8'h3C, 0, 1'b0);
        access(1'b0, 'h12, 8'h00, 0, 1'b0);
        access(1'b0, 'h1A, 8'h00, 0, 1'b0);
        access(1'b0, 'h22, 8'h00, 0, 1'b0);
        access(1'b0, 'h2A, 8'h00, 0, 1'b0);
        // Write-allocate into empty set 5, then read it back
        access(1'b1, 'h05, 8'h77, 0, 1'b0);
        access(1'b0, 'h05, 8'h00, 0, 1'b0);
        // Stalled fill, then reset while the fill is outstanding
        access(1'b0, 'h13, 8'h00, 5, 1'b0);
        access(1'b0, 'h14, 8'h00, 0, 1'b1);
        access(1'b0, 'h12, 8'h00, 0, 1'b0);

        // Randomized stream over 8 tags per set to force evictions
        for (int i = 0; i < 300; i++) begin
            access(1'($urandom_range(0, 1)), $urandom_range(0, 63), DW'($urandom),
                   $urandom_range(0, 2), 1'b0);
        end
`ifdef CACHE_STATS_EN
        @(negedge clk);
        chk("stats_hits", hit_count, 32'(m_hits));
        chk("stats_misses", miss_count, 32'(m_misses));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
